// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART.
//   - register offsets within the block (word aligned)
//   - STATUS register bit positions
//   - uart_state_t, the state type used by both the TX and RX FSMs
//   - clamp_div(): lowest usable clocks-per-bit value
package uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_RXDATA = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;
    localparam logic [3:0] UART_DIV    = 4'hC;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_TX_OVF    = 5;
    localparam int ST_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // A divisor below 2 would leave no room for the mid-bit RX sample.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/mmio_uart_if.sv
// mmio_uart_if: CPU data-port slice seen by the UART.
//   i_sel    access targets the UART this cycle
//   i_addr   byte offset within the block (bits [1:0] ignored)
//   i_we     1 = write, 0 = read
//   i_width  access width code (the UART treats every access as a word)
//   i_wdata  write data
//   o_rdata  read data, valid the cycle after the request
interface mmio_uart_if;
    logic        i_sel;
    logic [3:0]  i_addr;
    logic        i_we;
    logic [1:0]  i_width;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (
        output i_sel, i_addr, i_we, i_width, i_wdata,
        input  o_rdata
    );

    modport slave (
        input  i_sel, i_addr, i_we, i_width, i_wdata,
        output o_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push/i_wdata write an entry (ignored when full, unless popping too)
//   i_pop          drop the head entry (ignored when empty)
//   o_rdata        current head entry (stale when empty)
//   o_full/o_empty/o_count occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];

    // When full, a push is still taken if the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART target on the CPU data port.
//   i_clk, i_rst  clock, asynchronous active-high reset
//   bus           register access port (mmio_uart_if.slave), read data one cycle later
//   o_tx          serial out, idle high, LSB first
//   i_rx          serial in, asynchronous to i_clk
//   o_irq         high while the RX FIFO holds data
//
// Both FSMs use uart_state_t:
//   state   | TX meaning                       | RX meaning
//   S_IDLE  | line high, waiting for a byte    | waiting for a falling edge
//   S_START | driving start bit (DIV cycles)   | waiting to mid-sample start bit
//   S_DATA  | driving data bits 0..7           | sampling data bits 0..7
//   S_STOP  | driving stop bit (DIV cycles)    | waiting to sample stop bit
module mmio_uart
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mmio_uart_if.slave  bus,
    output logic        o_tx,
    input  logic        i_rx,
    output logic        o_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- register decode ----------------
    logic [3:0] reg_addr;
    logic       rd_req, wr_req;
    logic       wr_txdata, rd_rxdata, wr_status, wr_div;

    assign reg_addr  = {bus.i_addr[3:2], 2'b00};
    assign rd_req    = bus.i_sel && !bus.i_we;
    assign wr_req    = bus.i_sel && bus.i_we;
    assign wr_txdata = wr_req && (reg_addr == UART_TXDATA);
    assign rd_rxdata = rd_req && (reg_addr == UART_RXDATA);
    assign wr_status = wr_req && (reg_addr == UART_STATUS);
    assign wr_div    = wr_req && (reg_addr == UART_DIV);

    // ---------------- FIFOs ----------------
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;

    logic [7:0]    rx_shift_q, rx_shift_d;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (tx_push),
        .i_wdata (bus.i_wdata[7:0]),
        .i_pop   (tx_pop),
        .o_rdata (tx_head),
        .o_full  (tx_full),
        .o_empty (tx_empty),
        .o_count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (rx_push),
        .i_wdata (rx_shift_q),
        .i_pop   (rx_pop),
        .o_rdata (rx_head),
        .o_full  (rx_full),
        .o_empty (rx_empty),
        .o_count (rx_count)
    );

    // ---------------- CSR state ----------------
    logic [15:0] div_q, div_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] rdata_q, rdata_d;

    // ---------------- TX FSM ----------------
    uart_state_t tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_out_q, tx_out_d;
    logic        tx_busy;

    assign tx_busy = (tx_state_q != S_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_div_d   = div_q;
                    tx_cnt_d   = div_q - 16'd1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = tx_div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    // Chain straight into the next frame so queued bytes
                    // go out with no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_div_d   = div_q;
                        tx_cnt_d   = div_q - 16'd1;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Registered line driver: lags the state by one cycle, so a byte written
    // at edge N is popped at N+1 and the start bit appears at N+2.
    always_comb begin
        tx_out_d = 1'b1;
        unique case (tx_state_q)
            S_START: tx_out_d = 1'b0;
            S_DATA:  tx_out_d = tx_shift_q[0];
            default: tx_out_d = 1'b1;
        endcase
    end

    assign tx_push = wr_txdata;

    // ---------------- RX FSM ----------------
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_t rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_done_ok, rx_done_bad;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done_ok  = 1'b0;
        rx_done_bad = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_div_d   = div_q;
                    rx_cnt_d   = (div_q >> 1) - 16'd1;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_cnt_d   = rx_div_q - 16'd1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = rx_div_q - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_done_ok  = rx_sync_q;
                    rx_done_bad = !rx_sync_q;
                    rx_state_d  = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign rx_push = rx_done_ok;
    assign rx_pop  = rd_rxdata && !rx_empty;

    // ---------------- CSR next state ----------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'd0;
        unique case (reg_addr)
            UART_RXDATA: rd_val = rx_empty ? 32'd0 : {1'b1, 23'd0, rx_head};
            UART_STATUS: begin
                rd_val[ST_TX_FULL]   = tx_full;
                rd_val[ST_TX_EMPTY]  = tx_empty && !tx_busy;
                rd_val[ST_RX_VALID]  = !rx_empty;
                rd_val[ST_RX_OVR]    = rx_ovr_q;
                rd_val[ST_TX_BUSY]   = tx_busy;
                rd_val[ST_TX_OVF]    = tx_ovf_q;
                rd_val[ST_FRAME_ERR] = frame_err_q;
            end
            UART_DIV:    rd_val = {16'd0, div_q};
            default:     rd_val = 32'd0;
        endcase
    end

    always_comb begin
        div_d = div_q;
        if (wr_div) div_d = clamp_div(bus.i_wdata[15:0]);

        // Clear first, then set: a same-cycle event keeps the bit high.
        rx_ovr_d    = rx_ovr_q    && !(wr_status && bus.i_wdata[ST_RX_OVR]);
        tx_ovf_d    = tx_ovf_q    && !(wr_status && bus.i_wdata[ST_TX_OVF]);
        frame_err_d = frame_err_q && !(wr_status && bus.i_wdata[ST_FRAME_ERR]);
        if (rx_done_ok && rx_full && !rx_pop)   rx_ovr_d    = 1'b1;
        if (wr_txdata && tx_full && !tx_pop)    tx_ovf_d    = 1'b1;
        if (rx_done_bad)                        frame_err_d = 1'b1;

        rdata_d = rdata_q;
        if (bus.i_sel) rdata_d = bus.i_we ? 32'd0 : rd_val;
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= DEFAULT_DIV;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_out_q    <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_div_q    <= DEFAULT_DIV;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            div_q       <= DEFAULT_DIV;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_out_q    <= tx_out_d;
            rx_meta_q   <= i_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_div_q    <= rx_div_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            div_q       <= div_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_ovf_q    <= tx_ovf_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_tx        = tx_out_q;
    assign o_irq       = !rx_empty;
    assign bus.o_rdata = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{bus.i_width, bus.i_addr[1:0], bus.i_wdata[31:16],
                           tx_count, rx_count};

endmodule

// File: tb/tb_mmio_uart.sv
module tb_mmio_uart;
    import uart_pkg::*;

    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic o_tx, o_irq;
    logic rx_drv = 1'b1;
    logic loopback = 1'b0;
    logic rx_line;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_line = loopback ? o_tx : rx_drv;

    mmio_uart_if bus ();

    mmio_uart #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIV(16'd217)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus),
        .o_tx  (o_tx),
        .i_rx  (rx_line),
        .o_irq (o_irq)
    );

    // Serial-line observer: decodes 8N1 frames on o_tx by mid-bit sampling.
    logic       mon_en = 1'b0;
    int         mon_div = 16;
    logic [7:0] mon_bytes[$];
    logic       mon_stop[$];
    int         mon_start[$];
    int         mon_t0;
    logic [7:0] mon_b;
    logic       mon_ok;

    always begin
        @(negedge clk);
        if (mon_en && o_tx === 1'b0) begin
            mon_t0 = cyc;
            repeat (mon_div / 2) @(negedge clk);
            mon_ok = (o_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(negedge clk);
                mon_b[i] = o_tx;
            end
            repeat (mon_div) @(negedge clk);
            mon_ok = mon_ok && (o_tx === 1'b1);
            mon_bytes.push_back(mon_b);
            mon_stop.push_back(mon_ok);
            mon_start.push_back(mon_t0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.i_sel   = 1'b1;
        bus.i_we    = 1'b1;
        bus.i_addr  = a | 4'($urandom_range(0, 3));
        bus.i_width = 2'($urandom);
        bus.i_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.i_sel = 1'b0;
        bus.i_we  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.i_sel   = 1'b1;
        bus.i_we    = 1'b0;
        bus.i_addr  = a | 4'($urandom_range(0, 3));
        bus.i_width = 2'($urandom);
        bus.i_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.i_sel = 1'b0;
        d = bus.o_rdata;
    endtask

    task automatic rx_send(input logic [7:0] b, input int div, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Expected line level at frame cycle k is bit k/div of {stop, data, start}.
    task automatic tx_frame_check(input int div, input logic [7:0] b);
        logic [9:0]  fr;
        logic [31:0] r;
        fr = {1'b1, b, 1'b0};
        bus_write(UART_TXDATA, {24'h0, b});
        @(negedge clk);
        check("tx_latency_still_high", 32'(o_tx), 32'd1);
        for (int k = 0; k < 10 * div; k++) begin
            @(negedge clk);
            check($sformatf("tx_div%0d_bit%0d_cyc%0d", div, k / div, k), 32'(o_tx), 32'(fr[k / div]));
        end
        repeat (2) @(negedge clk);
        bus_read(UART_STATUS, r);
        check("tx_empty_after_frame", r, 32'h2);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  exp_q[$];
        logic        exp_ovr;
        int          div;

        bus.i_sel   = 1'b0;
        bus.i_we    = 1'b0;
        bus.i_addr  = 4'h0;
        bus.i_width = 2'b00;
        bus.i_wdata = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_rdata", bus.o_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        bus_read(UART_STATUS, r);  check("rst_status", r, 32'h2);
        bus_read(UART_DIV, r);     check("rst_div", r, 32'd217);
        bus_write(UART_DIV, 32'h1);
        bus_read(UART_DIV, r);     check("div_clamp_1", r, 32'd2);
        bus_write(UART_DIV, 32'hABCD0000);
        bus_read(UART_DIV, r);     check("div_clamp_0", r, 32'd2);
        bus_write(UART_DIV, 32'hFFFF0004);
        bus_read(UART_DIV, r);     check("div_upper_zero", r, 32'd4);
        bus_read(UART_TXDATA, r);  check("txdata_reads_0", r, 32'd0);
        bus_read(UART_RXDATA, r);  check("rxdata_empty_0", r, 32'd0);

        // TX waveform: fixed pattern, minimum divisor, random divisor
        tx_frame_check(4, 8'h55);
        bus_write(UART_DIV, 32'h0);
        tx_frame_check(2, 8'($urandom));
        div = $urandom_range(3, 7);
        bus_write(UART_DIV, 32'(div));
        tx_frame_check(div, 8'($urandom));

        // Loopback
        loopback = 1'b1;
        bus_write(UART_DIV, 32'd8);
        bus_write(UART_TXDATA, 32'hA3);
        for (int n = 0; n < 300 && o_irq !== 1'b1; n++) @(negedge clk);
        check("lb_irq_set", 32'(o_irq), 32'd1);
        bus_read(UART_RXDATA, r);  check("lb_rxdata", r, 32'h800000A3);
        check("lb_irq_clear", 32'(o_irq), 32'd0);
        repeat (3) @(negedge clk);
        check("rdata_holds", bus.o_rdata, 32'h800000A3);
        bus_read(UART_RXDATA, r);  check("lb_rx_empty", r, 32'd0);
        repeat (20) @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            div = $urandom_range(4, 12);
            b   = 8'($urandom);
            bus_write(UART_DIV, 32'(div));
            bus_write(UART_TXDATA, {24'h0, b});
            for (int n = 0; n < 20 * div && o_irq !== 1'b1; n++) @(negedge clk);
            check($sformatf("lb_rand%0d_irq", t), 32'(o_irq), 32'd1);
            bus_read(UART_RXDATA, r);
            check($sformatf("lb_rand%0d_data", t), r, {1'b1, 23'd0, b});
            repeat (2 * div + 4) @(negedge clk);
        end
        loopback = 1'b0;

        // TX overflow with back-to-back writes
        bus_write(UART_DIV, 32'd16);
        mon_div = 16;
        mon_bytes.delete(); mon_stop.delete(); mon_start.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) bus_write(UART_TXDATA, 32'(i));
        bus_read(UART_STATUS, r);  check("ovf_status", r, 32'h31);
        for (int n = 0; n < 2000 && mon_bytes.size() < FIFO_DEPTH + 1; n++) @(negedge clk);
        check("ovf_frame_count", 32'(mon_bytes.size()), 32'(FIFO_DEPTH + 1));
        for (int i = 0; i <= FIFO_DEPTH && i < mon_bytes.size(); i++) begin
            check($sformatf("ovf_byte%0d", i), 32'(mon_bytes[i]), 32'(i));
            check($sformatf("ovf_stop%0d", i), 32'(mon_stop[i]), 32'd1);
            if (i > 0)
                check($sformatf("ovf_gap%0d", i), 32'(mon_start[i] - mon_start[i-1]), 32'd160);
        end
        mon_en = 1'b0;
        repeat (20) @(negedge clk);
        bus_write(UART_STATUS, 32'h20);
        bus_read(UART_STATUS, r);  check("ovf_cleared", r, 32'h2);

        // Framing error, glitch rejection, recovery
        bus_write(UART_DIV, 32'd8);
        rx_send(8'($urandom), 8, 1'b0);
        bus_read(UART_STATUS, r);  check("frame_err_status", r, 32'h42);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_irq", 32'(o_irq), 32'd0);
        bus_read(UART_STATUS, r);  check("glitch_status", r, 32'h42);
        b = 8'($urandom);
        rx_send(b, 8, 1'b1);
        check("recover_irq", 32'(o_irq), 32'd1);
        bus_read(UART_RXDATA, r);  check("recover_data", r, {1'b1, 23'd0, b});
        bus_write(UART_STATUS, 32'h40);
        bus_read(UART_STATUS, r);  check("frame_err_cleared", r, 32'h2);

        // RX overrun
        exp_q.delete();
        exp_ovr = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
            else                           exp_ovr = 1'b1;
            rx_send(b, 8, 1'b1);
        end
        bus_read(UART_STATUS, r);
        check("ovr_status", r, {28'd0, exp_ovr, 3'b110});
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus_read(UART_RXDATA, r);
            check($sformatf("ovr_read%0d", i), r, {1'b1, 23'd0, exp_q.pop_front()});
        end
        bus_read(UART_RXDATA, r);  check("ovr_read_empty", r, 32'd0);
        check("ovr_irq_low", 32'(o_irq), 32'd0);
        bus_write(UART_STATUS, 32'h08);
        bus_read(UART_STATUS, r);  check("ovr_cleared", r, 32'h2);

        // Reset during the third data bit
        b = 8'($urandom) & 8'hFB;
        bus_write(UART_TXDATA, {24'h0, b});
        repeat (30) @(negedge clk);
        check("pre_rst_bit2_low", 32'(o_tx), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_tx_high", 32'(o_tx), 32'd1);
        check("rst_mid_rdata", bus.o_rdata, 32'd0);
        check("rst_mid_irq", 32'(o_irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_line_idle", 32'(o_tx), 32'd1);
        bus_read(UART_DIV, r);     check("post_rst_div", r, 32'd217);
        bus_read(UART_STATUS, r);  check("post_rst_status", r, 32'h2);
        bus_read(UART_RXDATA, r);  check("post_rst_rx_empty", r, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
Memory-mapped UART responder on the CPU data port: the target end of the core's load/store interface, selected by the memory controller's address decode. Accepts word-mapped register reads/writes, serialises TX bytes onto o_tx (8N1, LSB first) and deserialises i_rx into a receive FIFO. Read data is registered with one-cycle latency, matching the synchronous memories on the same port.

Parameters:
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, at least 2.
DEFAULT_DIV, 217, reset value of the clocks-per-bit divisor (25 MHz / 115200).

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_sel  input  1  access targets this block this cycle (address decode from the memory controller)
i_addr  input  4  byte offset within block; bits [1:0] ignored
i_we  input  1  1 = write, 0 = read
i_width  input  2  access width code; ignored, every access treated as a word
i_wdata  input  32  write data
o_rdata  output  32  read data, valid the cycle after the request
o_tx  output  1  serial out, idle high
i_rx  input  1  serial in, asynchronous to i_clk
o_irq  output  1  level: RX FIFO non-empty

Behaviour:
- Reset (async): o_tx=1, o_rdata=0, o_irq=0, both FIFOs empty, sticky bits 0, divisor=DEFAULT_DIV, both FSMs IDLE. Reset mid-frame aborts the frame; o_tx goes high immediately.
- Register map (side effects only when i_sel=1):
  - 0x0 TXDATA:
    - Write pushes i_wdata[7:0] into the TX FIFO.
    - If the FIFO is full, the byte is dropped and TX_OVF is set.
    - Read returns 0.
  - 0x4 RXDATA:
    - Read returns {rx_valid, 23'b0, head byte}.
    - If rx_valid, the head entry is popped at the request edge.
    - If the FIFO is empty, returns 0.
    - Writes are ignored.
  - 0x8 STATUS (read):
    - bit0 tx_full, bit1 tx_empty (FIFO empty and shifter idle), bit2 rx_valid.
    - bit3 RX_OVR, bit4 tx_busy, bit5 TX_OVF, bit6 FRAME_ERR.
    - Writing 1 to bits 3, 5 or 6 clears that bit. A set event in the same cycle as a clear wins.
  - 0xC DIVISOR:
    - Read/write, bits [15:0].
    - Writes below 2 store 2.
    - Upper bits read 0.
- o_rdata: registered from the request cycle; holds its last value when i_sel=0.
- TX FSM:
  - States: IDLE, START, DATA, STOP.
  - Divisor is latched on leaving IDLE. A mid-frame divisor change applies to the next frame.
  - IDLE with FIFO non-empty: pop, go to START. A byte written at edge N drives o_tx low from edge N+2.
  - START: o_tx=0 for DIV cycles.
  - DATA: bits 0..7, DIV cycles each.
  - STOP: o_tx=1 for DIV cycles, then back to IDLE. Back-to-back frames have no extra idle cycles.
- RX FSM:
  - Input path: i_rx passes through a 2-flop synchroniser. States: IDLE, START, DATA, STOP.
  - IDLE: synchronised falling edge latches the divisor and enters START.
  - START: sample at floor(DIV/2) cycles. If the line is high, treat as a glitch and return to IDLE.
  - DATA: 8 samples, DIV cycles apart.
  - STOP: sampled DIV cycles after the last data bit.
    - Stop=1: push the byte; if the RX FIFO is full, drop it and set RX_OVR.
    - Stop=0: discard the byte and set FRAME_ERR.
    - Either way return to IDLE.
- Simultaneous RX push and RXDATA pop on a full FIFO: both occur, no overrun.
- Simultaneous TXDATA push and shifter pop on a full FIFO: the push is accepted.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.

Decomposition:
- Package uart_pkg holds register offsets (UART_TXDATA=4'h0, UART_RXDATA=4'h4, UART_STATUS=4'h8, UART_DIV=4'hC), STATUS bit indices, and the uart_state_t enum shared by both FSMs.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, async reset), instantiated twice.

Test Plan:
- DIVISOR=4, write 0x55 to 0x0 at edge N -> o_tx low from N+2. Then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high. Frame is 40 cycles; STATUS bit1 returns to 1 afterwards.
- Loopback o_tx->i_rx, DIVISOR=8, write 0xA3 -> after the frame o_irq=1. Read 0x4 returns 0x800000A3; next read returns 0x00000000 and o_irq=0.
- DIVISOR=16, 10 back-to-back TXDATA writes 0x00..0x09 -> 1 byte in the shifter, 8 in the FIFO, 0x09 dropped. STATUS bit5=1; bytes 0x00..0x08 appear on o_tx in order. Write 0x20 to 0x8 -> bit5=0.
- Drive i_rx with stop bit 0 -> FRAME_ERR=1, rx_valid=0. Then a 1-cycle-wide low glitch -> no byte pushed, FSM back in IDLE.
- Send FIFO_DEPTH+1 bytes into i_rx without reading -> RX_OVR=1. Reads return the first 8 bytes in order, then 0.
- Assert i_rst in the 3rd data bit of a TX frame -> o_tx=1 within the same cycle. All registers at reset values; DIVISOR reads 217.
